// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite responder terminating writes/reads into NUM_REGS registers, exported in parallel.
// Optional macro AXI_LITE_RESP_ERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi_lite_reg_responder #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned NUM_REGS = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic                           wvalid,
   output logic                           wready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [STRB_WIDTH-1:0]          wstrb,
   output logic                           bvalid,
   input  logic                           bready,
   output logic [1:0]                     bresp,
   input  logic                           arvalid,
   output logic                           arready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

   typedef logic [ADDR_WIDTH-1:0] axiAddrT;
   typedef logic [DATA_WIDTH-1:0] axiDataT;
   typedef logic [STRB_WIDTH-1:0] axiStrobeT;

   localparam int unsigned IDX_W = $clog2(NUM_REGS);
   typedef logic [IDX_W-1:0] idxT;

   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_RESP_ERR_EN
   localparam logic [1:0] RESP_MISS = 2'b10;
`else
   localparam logic [1:0] RESP_MISS = RESP_OKAY;
`endif

   typedef enum logic {W_IDLE, W_RESP} wStateT;
   typedef enum logic {R_IDLE, R_RESP} rStateT;

   wStateT    wState, wStateNext;
   rStateT    rState, rStateNext;
   logic      awHeld, wHeld;
   axiAddrT   awAddrQ;
   axiDataT   wDataQ;
   axiStrobeT wStrbQ;
   logic [1:0] brespQ, rrespQ;
   axiDataT   rdataQ;
   axiDataT   regFile [NUM_REGS];

   logic      commit;
   axiAddrT   awOffset, arOffset;
   logic      wHit, arHit;
   idxT       wIdx, arIdx;
   logic      unusedAddrBits;

   // Offset is taken at full address width so an address below BASE_ADDR wraps
   // to a large value; the explicit compare rejects it regardless.
   always_comb begin
      awOffset = awAddrQ - BASE_ADDR;
      arOffset = araddr - BASE_ADDR;
      wHit     = (awAddrQ >= BASE_ADDR) && (awOffset[ADDR_WIDTH-1:IDX_W+2] == '0);
      arHit    = (araddr >= BASE_ADDR) && (arOffset[ADDR_WIDTH-1:IDX_W+2] == '0);
      wIdx     = awOffset[IDX_W+1:2];
      arIdx    = arOffset[IDX_W+1:2];
   end

   assign unusedAddrBits = ^{awOffset[1:0], arOffset[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         wState <= W_IDLE;
         rState <= R_IDLE;
      end else begin
         wState <= wStateNext;
         rState <= rStateNext;
      end
   end

   always_comb begin
      wStateNext = wState;
      awready    = 1'b0;
      wready     = 1'b0;
      bvalid     = 1'b0;
      commit     = 1'b0;
      unique case (wState)
         W_IDLE: begin
            awready = !awHeld;
            wready  = !wHeld;
            if (awHeld && wHeld) begin
               commit     = 1'b1;
               wStateNext = W_RESP;
            end
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) wStateNext = W_IDLE;
         end
         default: wStateNext = W_IDLE;
      endcase
   end

   always_comb begin
      rStateNext = rState;
      arready    = 1'b0;
      rvalid     = 1'b0;
      unique case (rState)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) rStateNext = R_RESP;
         end
         R_RESP: begin
            rvalid = 1'b1;
            if (rready) rStateNext = R_IDLE;
         end
         default: rStateNext = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         awHeld  <= 1'b0;
         wHeld   <= 1'b0;
         awAddrQ <= '0;
         wDataQ  <= '0;
         wStrbQ  <= '0;
         brespQ  <= RESP_OKAY;
         rdataQ  <= '0;
         rrespQ  <= RESP_OKAY;
         for (int unsigned i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
      end else begin
         if (awvalid && awready) begin
            awHeld  <= 1'b1;
            awAddrQ <= awaddr;
         end
         if (wvalid && wready) begin
            wHeld  <= 1'b1;
            wDataQ <= wdata;
            wStrbQ <= wstrb;
         end
         if (commit) begin
            awHeld <= 1'b0;
            wHeld  <= 1'b0;
            brespQ <= wHit ? RESP_OKAY : RESP_MISS;
            if (wHit) begin
               for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                  if (wStrbQ[b]) regFile[wIdx][b*8 +: 8] <= wDataQ[b*8 +: 8];
               end
            end
         end
         // Sampled before this edge's commit lands, so a colliding read sees the old value.
         if (rState == R_IDLE && arvalid) begin
            rdataQ <= arHit ? regFile[arIdx] : '0;
            rrespQ <= arHit ? RESP_OKAY : RESP_MISS;
         end
      end
   end

   assign bresp = brespQ;
   assign rdata = rdataQ;
   assign rresp = rrespQ;

   always_comb begin
      regs_o = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regFile[i];
   end

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Bench for axi_lite_reg_responder: vector table, hand-written corner sequences and
// randomized traffic against an array model of the register bank.
module tb_axi_lite_reg_responder;

   localparam logic [1:0] OK = 2'b00;
`ifdef AXI_LITE_RESP_ERR_EN
   localparam logic [1:0] MISS = 2'b10;
`else
   localparam logic [1:0] MISS = 2'b00;
`endif
   localparam int NREG = 16;

   logic clk = 1'b0;
   logic rst;
   logic awvalid, awready, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0] wstrb;
   logic [1:0] bresp, rresp;
   logic [NREG*32-1:0] regs_o;

   axi_lite_reg_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .NUM_REGS(NREG), .BASE_ADDR(32'h0)
   ) dut (
      .clk(clk), .rst(rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .regs_o(regs_o)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nFail = 0;
   logic [31:0] model [NREG];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic bit inRange(input logic [31:0] a);
      return (a / 4) < NREG;
   endfunction

   function automatic logic [1:0] expResp(input logic [31:0] a);
      return inRange(a) ? OK : MISS;
   endfunction

   task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (inRange(a))
         for (int b = 0; b < 4; b++)
            if (s[b]) model[a / 4][b*8 +: 8] = d[b*8 +: 8];
   endtask

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      return inRange(a) ? model[a / 4] : 32'h0;
   endfunction

   task automatic checkRegs();
      for (int i = 0; i < NREG; i++) check($sformatf("regs_o[%0d]", i), regs_o[i*32 +: 32], model[i]);
   endtask

   task automatic axiWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awDly, input int wDly, input int bDly, output logic [1:0] resp);
      bit awDone = 0;
      bit wDone = 0;
      int cyc = 0;
      resp = 2'bxx;
      while (!(awDone && wDone) && cyc < 40) begin
         @(negedge clk);
         if (awDone) check("awready_low_after_aw", {31'b0, awready}, 32'd0);
         if (wDone) check("wready_low_after_w", {31'b0, wready}, 32'd0);
         awvalid = !awDone && (cyc >= awDly);
         wvalid  = !wDone && (cyc >= wDly);
         awaddr = a; wdata = d; wstrb = s;
         if (awvalid && awready) awDone = 1;
         if (wvalid && wready) wDone = 1;
         cyc++;
      end
      if (!(awDone && wDone)) begin
         check("aw_w_handshake_timeout", 32'd0, 32'd1);
         awvalid = 0; wvalid = 0;
         return;
      end
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      check("bvalid_not_early", {31'b0, bvalid}, 32'd0);
      @(negedge clk);
      check("bvalid_latency", {31'b0, bvalid}, 32'd1);
      resp = bresp;
      for (int i = 0; i < bDly; i++) begin
         @(negedge clk);
         awvalid = 1;
         check("bvalid_hold", {31'b0, bvalid}, 32'd1);
         check("bresp_hold", {30'b0, bresp}, {30'b0, resp});
         check("awready_in_resp", {31'b0, awready}, 32'd0);
         check("wready_in_resp", {31'b0, wready}, 32'd0);
      end
      awvalid = 0;
      bready = 1;
      @(negedge clk);
      bready = 0;
      check("bvalid_cleared", {31'b0, bvalid}, 32'd0);
      check("ready_after_b", {30'b0, awready, wready}, 32'd3);
   endtask

   task automatic axiRead(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int cyc = 0;
      d = 'x; resp = 'x;
      @(negedge clk);
      arvalid = 1; araddr = a;
      while (!arready && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      if (!arready) begin
         check("ar_handshake_timeout", 32'd0, 32'd1);
         arvalid = 0;
         return;
      end
      @(negedge clk);
      arvalid = 0;
      check("rvalid_latency", {31'b0, rvalid}, 32'd1);
      d = rdata; resp = rresp;
      rready = 1;
      @(negedge clk);
      rready = 0;
      check("rvalid_cleared", {31'b0, rvalid}, 32'd0);
      check("arready_after_r", {31'b0, arready}, 32'd1);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          awDly;
      int          wDly;
      int          bDly;
      logic [1:0]  expB;
      logic [31:0] expRd;
      logic [1:0]  expR;
   } vecT;

   vecT vecs[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] resp;
      logic [31:0] d;
      logic [31:0] a, wd;
      logic [3:0] s;

      vecs[0] = '{32'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, OK, 32'hDEAD_BEEF, OK};
      vecs[1] = '{32'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 5, OK, 32'hFFFF_FFFF, OK};
      vecs[2] = '{32'h00, 32'h1122_3344, 4'b0101, 3, 0, 0, OK, 32'hFF22_FF44, OK};
      vecs[3] = '{32'h40, 32'h1234_5678, 4'hF, 0, 0, 0, MISS, 32'h0, MISS};
      vecs[4] = '{32'h0E, 32'hAABB_CCDD, 4'hC, 0, 2, 1, OK, 32'hAABB_0000, OK};
      vecs[5] = '{32'h3C, 32'h0102_0304, 4'h0, 1, 1, 0, OK, 32'h0, OK};
      vecs[6] = '{32'h3F, 32'hCAFE_F00D, 4'h3, 0, 2, 0, OK, 32'h0000_F00D, OK};
      vecs[7] = '{32'hFFFF_FFFC, 32'h1, 4'hF, 0, 0, 0, MISS, 32'h0, MISS};
      vecs[8] = '{32'h44, 32'h5A5A_5A5A, 4'hF, 2, 0, 0, MISS, 32'h0, MISS};

      for (int i = 0; i < NREG; i++) model[i] = '0;
      rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
      repeat (3) @(negedge clk);
      check("reset_readies", {29'b0, awready, wready, arready}, 32'd7);
      check("reset_valids", {30'b0, bvalid, rvalid}, 32'd0);
      check("reset_resps", {28'b0, bresp, rresp}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      checkRegs();
      rst = 0;

      for (int i = 0; i < 9; i++) begin
         axiWrite(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].awDly, vecs[i].wDly, vecs[i].bDly, resp);
         modelWrite(vecs[i].addr, vecs[i].data, vecs[i].strb);
         check($sformatf("vec%0d_bresp", i), {30'b0, resp}, {30'b0, vecs[i].expB});
         axiRead(vecs[i].addr, d, resp);
         check($sformatf("vec%0d_rdata", i), d, vecs[i].expRd);
         check($sformatf("vec%0d_rresp", i), {30'b0, resp}, {30'b0, vecs[i].expR});
         checkRegs();
      end

      // Commit to reg 3 lands on the same edge as the AR capture of 0x0C.
      axiWrite(32'h0C, 32'h0, 4'hF, 0, 0, 0, resp);
      modelWrite(32'h0C, 32'h0, 4'hF);
      @(negedge clk);
      awvalid = 1; wvalid = 1; awaddr = 32'h0C; wdata = 32'h5; wstrb = 4'hF;
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      arvalid = 1; araddr = 32'h0C;
      @(negedge clk);
      arvalid = 0;
      check("collide_rvalid", {31'b0, rvalid}, 32'd1);
      check("collide_bvalid", {31'b0, bvalid}, 32'd1);
      check("collide_old_value", rdata, 32'h0);
      modelWrite(32'h0C, 32'h5, 4'hF);
      bready = 1; rready = 1;
      @(negedge clk);
      bready = 0; rready = 0;
      axiRead(32'h0C, d, resp);
      check("collide_new_value", d, 32'h5);

      // Reset while both responses are pending.
      @(negedge clk);
      awvalid = 1; wvalid = 1; awaddr = 32'h04; wdata = 32'h77; wstrb = 4'hF;
      arvalid = 1; araddr = 32'h04;
      @(negedge clk);
      awvalid = 0; wvalid = 0; arvalid = 0;
      @(negedge clk);
      check("pre_reset_valids", {30'b0, bvalid, rvalid}, 32'd3);
      rst = 1;
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < NREG; i++) model[i] = '0;
      check("post_reset_valids", {30'b0, bvalid, rvalid}, 32'd0);
      check("post_reset_readies", {29'b0, awready, wready, arready}, 32'd7);
      check("post_reset_rdata", rdata, 32'd0);
      checkRegs();

      // A captured AW must not survive reset and pair with a later W.
      awvalid = 1; awaddr = 32'h08;
      @(negedge clk);
      awvalid = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
      wvalid = 1; wdata = 32'h99; wstrb = 4'hF;
      @(negedge clk);
      wvalid = 0;
      repeat (3) begin
         @(negedge clk);
         check("no_b_from_stale_aw", {31'b0, bvalid}, 32'd0);
      end
      checkRegs();
      awvalid = 1; awaddr = 32'h08;
      @(negedge clk);
      awvalid = 0;
      @(negedge clk);
      @(negedge clk);
      check("late_aw_bvalid", {31'b0, bvalid}, 32'd1);
      bready = 1;
      @(negedge clk);
      bready = 0;
      modelWrite(32'h08, 32'h99, 4'hF);
      checkRegs();

      for (int n = 0; n < 150; n++) begin
         a = $urandom_range(0, 19) * 4 + $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin
            wd = $urandom;
            s = 4'($urandom_range(0, 15));
            axiWrite(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp);
            modelWrite(a, wd, s);
            check("rand_bresp", {30'b0, resp}, {30'b0, expResp(a)});
         end else begin
            axiRead(a, d, resp);
            check("rand_rdata", d, modelRead(a));
            check("rand_rresp", {30'b0, resp}, {30'b0, expResp(a)});
         end
      end
      checkRegs();

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
      $finish;
   end

endmodule
